// File: rtl/seq_timer.sv
// Sequencer-attached timer: prescaled down-counter with one-shot
// and auto-reload modes, driven by 12-bit commands on one oreg slot.
module seq_timer #(
  parameter int unsigned SLOT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] oreg,
  input  logic [7:0]  oreg_wen,
  output logic [7:0]  ireg,
  output logic        tick,
  output logic        busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDCNT = 4'h1;
  localparam logic [3:0] OP_LDPRE = 4'h2;
  localparam logic [3:0] OP_START = 4'h3;
  localparam logic [3:0] OP_STOP  = 4'h4;
  localparam logic [3:0] OP_MODE  = 4'h5;
  localparam logic [3:0] OP_CLR   = 4'h6;
  localparam logic [3:0] OP_SEL   = 4'h7;

  localparam logic [2:0] SLOT_IDX = 3'(SLOT);

  state_e     state_q, state_d;
  logic [7:0] r_q, r_d;
  logic [7:0] p_q, p_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pc_q, pc_d;
  logic       auto_q, auto_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [1:0] sel_q, sel_d;
  logic       tick_q, tick_d;

  logic       cmd_w;
  logic [3:0] op_w;
  logic [7:0] dat_w;
  logic       start_ok_w;
  logic       win_w;
  logic       run_w;
  logic       expire_w;
  logic       wen_unused;

  assign cmd_w      = oreg_wen[SLOT_IDX];
  assign op_w       = oreg[11:8];
  assign dat_w      = oreg[7:0];
  assign wen_unused = ^oreg_wen;

  assign start_ok_w = r_q != 8'd0;
  // START/STOP pre-empt counting and expiry on the same edge
  assign win_w = cmd_w &&
                 ((op_w == OP_STOP) ||
                  ((op_w == OP_START) && start_ok_w));
  assign run_w    = (state_q == S_RUN) && !win_w;
  assign expire_w = run_w && (pc_q == 8'd0) &&
                    (cnt_q == 8'd1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      r_q     <= 8'd0;
      p_q     <= 8'd0;
      cnt_q   <= 8'd0;
      pc_q    <= 8'd0;
      auto_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= 2'd0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      auto_q  <= auto_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    auto_d  = auto_q;
    done_d  = done_q;
    err_d   = err_q;
    sel_d   = sel_q;
    tick_d  = 1'b0;

    if (cmd_w) begin
      case (op_w)
        OP_LDCNT: r_d = dat_w;
        OP_LDPRE: p_d = dat_w;
        OP_START: begin
          if (start_ok_w) begin
            cnt_d   = r_q;
            pc_d    = p_q;
            err_d   = 1'b0;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_STOP:  state_d = S_IDLE;
        OP_MODE:  auto_d = dat_w[0];
        OP_CLR: begin
          done_d = 1'b0;
          err_d  = 1'b0;
        end
        OP_SEL:   sel_d = dat_w[1:0];
        OP_NOP:   ;
        default:  ;
      endcase
    end

    // counting runs after commands so expiry sets done last
    if (run_w) begin
      if (pc_q != 8'd0) begin
        pc_d = pc_q - 8'd1;
      end else begin
        pc_d = p_q;
        if (cnt_q > 8'd1) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
    end

    if (expire_w) begin
      tick_d = 1'b1;
      done_d = 1'b1;
      if (auto_q) begin
        cnt_d = r_q;
      end else begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    end
  end

  always_comb begin
    busy = state_q == S_RUN;
    tick = tick_q;
    ireg = 8'd0;
    unique case (sel_q)
      2'd0: ireg = cnt_q;
      2'd1: ireg = r_q;
      2'd2: ireg = p_q;
      2'd3: ireg = {done_q, busy, auto_q,
                    err_q, 4'b0000};
      default: ireg = 8'd0;
    endcase
  end

endmodule

// File: tb/tb_seq_timer.sv
// Directed and random bench for seq_timer (SLOT=2) against
// a behavioural model of the command/count rules.
module tb_seq_timer;

  logic        clock;
  logic        reset;
  logic [11:0] oreg;
  logic [7:0]  oreg_wen;
  logic [7:0]  ireg;
  logic        tick;
  logic        busy;

  seq_timer #(.SLOT(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .oreg     (oreg),
    .oreg_wen (oreg_wen),
    .ireg     (ireg),
    .tick     (tick),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors;
  int miscompares;

  int m_r, m_p, m_cnt, m_pc, m_sel;
  bit m_run, m_auto, m_done, m_err, m_tick;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model(input logic rst,
                       input logic hit,
                       input logic [3:0] op,
                       input logic [7:0] d);
    int o_r, o_p, o_cnt, o_pc;
    bit o_run, o_auto, win, expiry;
    if (!rst) begin
      m_r = 0; m_p = 0; m_cnt = 0; m_pc = 0;
      m_sel = 0; m_run = 0; m_auto = 0;
      m_done = 0; m_err = 0; m_tick = 0;
      return;
    end
    o_r = m_r; o_p = m_p; o_cnt = m_cnt; o_pc = m_pc;
    o_run = m_run; o_auto = m_auto;
    win = hit && (op == 4'h4 ||
                  (op == 4'h3 && o_r != 0));
    expiry = o_run && !win && o_pc == 0 && o_cnt == 1;
    m_tick = expiry;
    if (o_run && !win) begin
      if (o_pc > 0) m_pc = o_pc - 1;
      else begin
        m_pc = o_p;
        if (o_cnt > 1) m_cnt = o_cnt - 1;
      end
    end
    if (expiry) begin
      m_done = 1;
      if (o_auto) m_cnt = o_r;
      else begin
        m_cnt = 0;
        m_run = 0;
      end
    end
    if (hit) begin
      case (op)
        4'h1: m_r = d;
        4'h2: m_p = d;
        4'h3: begin
          if (o_r != 0) begin
            m_cnt = o_r; m_pc = o_p;
            m_err = 0; m_run = 1;
          end else m_err = 1;
        end
        4'h4: m_run = 0;
        4'h5: m_auto = d[0];
        4'h6: begin
          m_err = 0;
          if (!expiry) m_done = 0;
        end
        4'h7: m_sel = int'(d[1:0]);
        default: ;
      endcase
    end
  endtask

  function automatic logic [7:0] m_ireg();
    case (m_sel)
      0: return 8'(m_cnt);
      1: return 8'(m_r);
      2: return 8'(m_p);
      default: return {m_done, m_run, m_auto,
                       m_err, 4'b0000};
    endcase
  endfunction

  task automatic step(input logic rst,
                      input logic [7:0] wen,
                      input logic [3:0] op,
                      input logic [7:0] d);
    @(negedge clock);
    reset    = rst;
    oreg_wen = wen;
    oreg     = {op, d};
    @(posedge clock);
    model(rst, wen[2], op, d);
    #1;
    chk("tick", {7'd0, tick}, {7'd0, m_tick});
    chk("busy", {7'd0, busy}, {7'd0, m_run});
    chk("ireg", ireg, m_ireg());
  endtask

  task automatic cmd(input logic [3:0] op,
                     input logic [7:0] d);
    step(1'b1, 8'h04, op, d);
  endtask

  int nticks;

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    oreg = 12'h000;
    oreg_wen = 8'h00;

    step(1'b0, 8'h00, 4'h0, 8'h00);
    step(1'b0, 8'h00, 4'h0, 8'h00);
    chk("rst_ireg", ireg, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    cmd(4'h7, 8'h03);
    chk("rst_sts", ireg, 8'h00);

    cmd(4'h1, 8'h03);
    cmd(4'h2, 8'h01);
    cmd(4'h3, 8'h00);
    chk("os_busy", {7'd0, busy}, 8'h01);
    nticks = 0;
    for (int i = 0; i < 5; i++) begin
      cmd(4'h0, 8'h00);
      if (tick) nticks++;
    end
    cmd(4'h0, 8'h00);
    chk("os_tick6", {7'd0, tick}, 8'h01);
    chk("os_early", 8'(nticks), 8'h00);
    cmd(4'h7, 8'h03);
    chk("os_sts", ireg, 8'h80);
    chk("os_idle", {7'd0, busy}, 8'h00);

    cmd(4'h7, 8'h00);
    nticks = 0;
    step(1'b1, 8'h01, 4'h1, 8'h03);
    step(1'b1, 8'h01, 4'h2, 8'h01);
    step(1'b1, 8'h01, 4'h3, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'h01, 4'h0, 8'h00);
      if (tick) nticks++;
    end
    chk("ws_ireg", ireg, 8'h00);
    chk("ws_ticks", 8'(nticks), 8'h00);

    cmd(4'h5, 8'h01);
    cmd(4'h1, 8'h02);
    cmd(4'h2, 8'h00);
    cmd(4'h3, 8'h00);
    nticks = 0;
    for (int i = 0; i < 10; i++) begin
      cmd(4'h0, 8'h00);
      if (tick) nticks++;
    end
    chk("ar_ticks", 8'(nticks), 8'h05);
    cmd(4'h4, 8'h00);
    chk("ar_stop", {7'd0, busy}, 8'h00);
    nticks = 0;
    for (int i = 0; i < 4; i++) begin
      cmd(4'h0, 8'h00);
      if (tick) nticks++;
    end
    chk("ar_quiet", 8'(nticks), 8'h00);
    chk("ar_held", ireg, 8'h02);

    cmd(4'h6, 8'h00);
    cmd(4'h5, 8'h00);
    cmd(4'h1, 8'h00);
    cmd(4'h3, 8'h00);
    chk("z_busy", {7'd0, busy}, 8'h00);
    cmd(4'h7, 8'h03);
    chk("z_err", ireg, 8'h10);
    cmd(4'h6, 8'h00);
    chk("z_clr", ireg, 8'h00);

    cmd(4'h1, 8'h03);
    cmd(4'h2, 8'h01);
    cmd(4'h3, 8'h00);
    for (int i = 0; i < 5; i++) cmd(4'h0, 8'h00);
    cmd(4'h3, 8'h00);
    chk("se_tick", {7'd0, tick}, 8'h00);
    chk("se_busy", {7'd0, busy}, 8'h01);
    nticks = 0;
    for (int i = 0; i < 5; i++) begin
      cmd(4'h0, 8'h00);
      if (tick) nticks++;
    end
    cmd(4'h0, 8'h00);
    chk("se_late", {7'd0, tick}, 8'h01);
    chk("se_early", 8'(nticks), 8'h00);

    cmd(4'h7, 8'h00);
    cmd(4'h1, 8'h05);
    cmd(4'h2, 8'h03);
    cmd(4'h3, 8'h00);
    cmd(4'h0, 8'h00);
    chk("mr_cnt", ireg, 8'h05);
    step(1'b0, 8'h04, 4'h3, 8'h00);
    chk("mr_busy", {7'd0, busy}, 8'h00);
    chk("mr_ireg", ireg, 8'h00);
    chk("mr_tick", {7'd0, tick}, 8'h00);
    cmd(4'h0, 8'h00);

    for (int i = 0; i < 600; i++) begin
      logic       r;
      logic [7:0] w;
      logic [3:0] op;
      logic [7:0] d;
      r  = ($urandom_range(0, 79) != 0);
      w  = 8'($urandom);
      if ($urandom_range(0, 9) < 7) w[2] = 1'b1;
      op = ($urandom_range(0, 2) == 0) ?
           4'($urandom) : 4'h0;
      d  = 8'($urandom);
      if (op == 4'h1) d = 8'($urandom_range(1, 7));
      if (op == 4'h2) d = 8'($urandom_range(0, 3));
      step(r, w, op, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_timer.md
Name: seq_timer

Overview:
- Timer/counter peripheral that sits directly downstream of the sequencer.
- It occupies one slot of the sequencer's `oreg`/`oreg_wen` command bus and executes the 12-bit commands addressed to it.
- It returns an 8-bit readback value that is wired to one of the sequencer's `ireg_N` inputs.
- It emits a one-cycle `tick` on each expiry, so sequencer programs can implement delays, periodic events and polling loops.

Parameters:
- SLOT, 0: index of the `oreg_wen` bit that addresses this block. Legal values are 0..7.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous reset, active-low; sampled on the rising edge of `clock`.
- oreg  in  12  command word: [11:8] opcode, [7:0] data.
- oreg_wen  in  8  per-slot command strobes. Only bit SLOT is examined; other bits are ignored.
- ireg  out  8  readback value, selected by SELRD; intended for the sequencer's `ireg_N`.
- tick  out  1  registered one-cycle pulse on expiry.
- busy  out  1  high while the state is RUN.

Behaviour:
- Reset (`reset`==0 at a rising edge):
  - State IDLE.
  - Registers R (reload), P (prescale), cnt, pc, auto, done, err, sel all cleared to 0.
  - `tick`=0, `busy`=0, `ireg`=0. Reset overrides any command in the same cycle, including a reset asserted mid-count.
- Command acceptance:
  - A command is executed at a rising edge when `reset`==1 and `oreg_wen[SLOT]`==1.
  - Exactly one command is executed per cycle. Back-to-back commands on consecutive cycles are all executed.
- Opcodes (d = `oreg[7:0]`):
  - 0x0 NOP: no effect.
  - 0x1 LDCNT: R<=d.
  - 0x2 LDPRE: P<=d.
  - 0x3 START:
    - If R!=0: cnt<=R, pc<=P, err<=0, state RUN.
    - If R==0: ignored, err<=1, state unchanged.
  - 0x4 STOP: state IDLE; cnt and pc hold their values.
  - 0x5 SETMODE: auto<=d[0].
  - 0x6 CLRFLAG: done<=0, err<=0.
  - 0x7 SELRD: sel<=d[1:0].
  - 0x8..0xF: ignored, treated as NOP.
- RUN counting, evaluated each edge in RUN:
  - If pc!=0: pc<=pc-1.
  - Otherwise pc<=P, and:
    - if cnt>1: cnt<=cnt-1;
    - if cnt==1: expiry.
- Expiry:
  - `tick`<=1 for exactly one cycle; done<=1.
  - If auto==1: cnt<=R, pc<=P, remain in RUN. The R value used is the value held before this edge.
  - If auto==0: cnt<=0, state IDLE.
- Timing: with no intervening commands, `tick` is first high R*(P+1) cycles after the START edge. With auto==1, it then repeats every R*(P+1) cycles.
- Simultaneous events:
  - START or STOP on an expiry edge: the command wins and no tick is produced. START restarts the count; STOP goes to IDLE.
  - Any other command on an expiry edge: the command and the expiry both take effect.
  - CLRFLAG together with expiry: done ends at 1 (set wins).
  - START while already in RUN: restarts from R and P.
- Width rules: all counters are 8-bit unsigned. No wrap-around is possible, because cnt never decrements below 1 in RUN.
- `ireg` is combinational from registers, so it reflects a write in the cycle after the writing edge. Selection by sel:
  - 0: cnt
  - 1: R
  - 2: P
  - 3: {done, busy, auto, err, 4'b0}
- `busy` = (state==RUN), combinational from the state register.
- `tick` is low at all other times, including while in IDLE.

Test Plan:
- Reset held low 2 cycles, then released → `ireg`=0x00, `tick`=0, `busy`=0. SELRD 3 → `ireg`=0x00.
- SLOT=2. LDCNT 0x03, LDPRE 0x01, START, all with `oreg_wen`=0x04 → `busy`=1; `tick` high exactly 6 cycles after the START edge for 1 cycle; then `busy`=0; SELRD 3 → `ireg`=0x80.
- Same sequence but `oreg_wen`=0x01 (wrong slot) → no state change, `ireg` stays 0, `tick` never asserts.
- SETMODE 0x01, LDCNT 0x02, LDPRE 0x00, START → `tick` every 2 cycles for 5 periods. Then STOP → `busy`=0, no further ticks, SELRD 0 shows the held cnt.
- LDCNT 0x00, START → `busy` stays 0; SELRD 3 → `ireg`=0x10. CLRFLAG → `ireg`=0x00.
- Boundary case: START issued on the expiry edge with auto=0 → no tick, `busy` stays 1, next tick R*(P+1) cycles later. Second boundary case: `reset` driven low while RUN with cnt=0x05 → next cycle `busy`=0, `ireg`=0, no tick.
